fp_mul_share_arbiter: RTL and testbench
=======================================

// Module: fp_mul_share_arbiter
// PURPOSE
//   Shares one FP_Multiplier (IEEE-754 single, fixed-latency, ports a,b -> S,of) among
//   NUM_REQ requesters. Round-robin arbitration; one multiply in flight at a time.
//   Operands are held stable on the multiplier for LATENCY cycles, then S/of are
//   sampled and returned to the winning requester via a valid/ready response.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..8)
//   ID_W      2   width of grant_id; must be >= clog2(NUM_REQ)
//   LATENCY   3   cycles the multiplier needs from stable a,b to valid S,of (>=1)
// PORTS
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous, active-high reset
//   req_valid  in   NUM_REQ      per-requester request
//   req_a      in   NUM_REQ*32   operand A, requester i at [32*i+:32]
//   req_b      in   NUM_REQ*32   operand B, same packing
//   req_ready  out  NUM_REQ      one-hot accept pulse
//   mul_a      out  32           to shared multiplier input a
//   mul_b      out  32           to shared multiplier input b
//   mul_s      in   32           from multiplier product S
//   mul_of     in   1            from multiplier overflow/underflow flag
//   resp_valid out  NUM_REQ      one-hot result valid to owner
//   resp_ready in   NUM_REQ      per-requester result accept
//   resp_s     out  32           product
//   resp_of    out  1            overflow flag captured with resp_s
//   grant_id   out  ID_W         index of current owner
//   busy       out  1            high in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, mul_a=mul_b=0, resp_s=0,
//     resp_of=0, grant_id=0, busy=0, wait counter=0. Reset in any state aborts the
//     operation; no response is produced for it.
//   FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, pick the first set bit searching rr_ptr, rr_ptr+1, ...
//     (mod NUM_REQ). req_ready[winner]=1 combinationally in that cycle only. At the edge:
//     mul_a/mul_b <= winner operands, grant_id <= winner, cnt <= 0, go WAIT.
//   WAIT: mul_a/mul_b held. cnt increments each edge. On the edge where
//     cnt==LATENCY-1: resp_s<=mul_s, resp_of<=mul_of, go RESP. WAIT thus lasts
//     exactly LATENCY cycles.
//   RESP: resp_valid[grant_id]=1, resp_s/resp_of stable until handshake. On
//     resp_valid&resp_ready[grant_id]: rr_ptr<=(grant_id+1) mod NUM_REQ, go IDLE.
//     resp_ready of other requesters is ignored.
//   Timing: accept edge E0 -> resp_valid high from E0+LATENCY. Min per-op period
//     LATENCY+2 cycles (1 IDLE, LATENCY WAIT, 1 RESP). No back-to-back grant from RESP.
//   req_valid changes outside IDLE are ignored; a requester deasserting after accept
//     still receives its response. Requester must hold req_valid until req_ready.
//   Arithmetic passes through unchanged: no rounding, zero or special-case handling
//     here; S=0 with of=1 from the multiplier is returned as-is.
//   rr_ptr wraps NUM_REQ-1 -> 0. If req_valid==0 in IDLE, stay IDLE with no outputs
//     changed.
//   Unused requester indices (>= NUM_REQ within ID_W) are never granted.
// TESTING (bench instantiates FP_Multiplier behind a LATENCY-cycle model)
//   1 Req0 a=b=0x42360000 (45.5) -> resp_valid[0] at E0+LATENCY, resp_s=0x45016400, of=0.
//   2 Req0..3 all valid together with 0x3F99999A x 0xC0133333 -> grants 0,1,2,3 in order,
//     each resp_s=0xC030A3D7; then only req1 valid -> granted (rr_ptr=0 wraps past 0).
//   3 Req2 a=b=0x7F514CCD -> resp_s=0x00000000, resp_of=1; resp_ready held low 5 cycles
//     -> resp_valid/resp_s stay stable, no new grant though req0 valid.
//   4 Req3 a=0x00000000, b=0xC2360000 -> resp_s=0x00000000; req3 drops req_valid during
//     WAIT -> response still delivered to index 3.
//   5 reset pulsed mid-WAIT -> next cycle busy=0, resp_valid=0, mul_a=0; pending
//     request re-granted from rr_ptr=0 and completes normally.
//   6 resp_ready asserted on wrong index during RESP -> no handshake, state stays RESP.

Source files
------------

// File: rtl/fp_mul_share_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency FP multiplier among NUM_REQ
// requesters. One multiply is in flight at a time. The winner's operands are held on
// the multiplier for LATENCY cycles, and the product is then returned on a valid/ready
// response channel.
module fp_mul_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_s,
  input  logic                  mul_of,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_s,
  output logic                  resp_of,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);

  localparam int unsigned    CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);
  localparam logic [ID_W-1:0] IdLast  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [31:0]     resp_s_q, resp_s_d;
  logic            resp_of_q, resp_of_d;

  logic            hi_found, lo_found, win_found;
  logic [ID_W-1:0] hi_id, lo_id, win_id;
  logic [31:0]     win_a, win_b;
  logic            resp_hs;

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    win_a    = '0;
    win_b    = '0;
    // Scan downwards so the last hit is the lowest index.
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(j);
        if (ID_W'(j) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(j);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (win_id == ID_W'(j)) begin
        win_a = req_a[32*j +: 32];
        win_b = req_b[32*j +: 32];
      end
    end
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      resp_s_q   <= '0;
      resp_of_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      resp_s_q   <= resp_s_d;
      resp_of_q  <= resp_of_d;
    end
  end

  // Next-state logic: accept in IDLE, count out the multiplier latency, await handshake.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    resp_s_d   = resp_s_q;
    resp_of_d  = resp_of_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          mul_a_d    = win_a;
          mul_b_d    = win_b;
          grant_id_d = win_id;
          cnt_d      = '0;
          state_d    = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          resp_s_d  = mul_s;
          resp_of_d = mul_of;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (resp_hs) begin
          rr_ptr_d = (grant_id_q == IdLast) ? '0 : grant_id_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: one-hot accept pulse in IDLE, one-hot response valid to the owner in RESP.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      // Gate with reset so no requester sees an accept for an op that will be dropped.
      req_ready[j]  = (state_q == StIdle) && !reset && win_found && (win_id == ID_W'(j));
      resp_valid[j] = (state_q == StResp) && (grant_id_q == ID_W'(j));
    end
    // resp_valid is one-hot, so only the owner's resp_ready can complete the handshake.
    resp_hs = |(resp_valid & resp_ready);
    busy    = (state_q != StIdle);
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign resp_s   = resp_s_q;
  assign resp_of  = resp_of_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fp_mul_share_arbiter.sv
// Bench for fp_mul_share_arbiter: a 3-cycle multiplier model with a table of known
// products, table-driven single-requester vectors, and hand-written multi-cycle cases.
module tb_fp_mul_share_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned LAT     = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  mul_a, mul_b, mul_s, resp_s;
  logic         mul_of, resp_of, busy;
  logic [1:0]   grant_id;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        of;
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  fp_mul_share_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W),
    .LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_s     (mul_s),
    .mul_of    (mul_of),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_s    (resp_s),
    .resp_of   (resp_of),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Multiplier stand-in: known products only; anything else yields a marker value.
  function automatic logic [32:0] mulf(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h42360000 && b == 32'h42360000) return {1'b0, 32'h45016400};
    if (a == 32'h3F99999A && b == 32'h C0133333) return {1'b0, 32'hC030A3D7};
    if (a == 32'h7F514CCD && b == 32'h7F514CCD) return {1'b1, 32'h00000000};
    if (a == 32'h00000000 && b == 32'hC2360000) return {1'b0, 32'h00000000};
    return {1'b0, 32'hDEADBEEF};
  endfunction

  // Result is valid LAT-1 edges after the operands settle, so it is ready for the
  // LAT-th edge after the load; any earlier sample returns a stale value.
  logic [32:0] pipe0 = '0;
  logic [32:0] pipe1 = '0;
  always @(posedge clk) begin
    pipe0 <= mulf(mul_a, mul_b);
    pipe1 <= pipe0;
  end
  assign mul_of = pipe1[32];
  assign mul_s  = pipe1[31:0];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  // Run one transaction for requester id, already presented by the caller.
  // Entered and left at posedge+1. stall = RESP cycles before resp_ready; wrong = drive
  // resp_ready on the other indices during the stall.
  task automatic op(input int id, input logic [31:0] es, input logic eo, input int stall,
                    input bit wrong);
    logic [3:0] oh;
    bit         got;
    int         n;
    oh  = 4'(1 << id);
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (req_ready != 4'b0) got = 1'b1;
      n++;
    end
    chk($sformatf("grant seen id%0d", id), 64'(got), 64'd1);
    if (!got) return;
    chk($sformatf("req_ready id%0d", id), 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    for (int k = 0; k < int'(LAT); k++) begin
      @(negedge clk);
      chk($sformatf("wait resp_valid id%0d c%0d", id, k), 64'(resp_valid), 64'd0);
      chk($sformatf("wait busy id%0d c%0d", id, k), 64'(busy), 64'd1);
      if (k == 0) begin
        chk($sformatf("mul_a id%0d", id), 64'(mul_a), 64'(req_a[32*id +: 32]));
        chk($sformatf("grant_id id%0d", id), 64'(grant_id), 64'(id));
      end
    end
    @(negedge clk);
    chk($sformatf("resp_valid id%0d", id), 64'(resp_valid), 64'(oh));
    chk($sformatf("resp_s id%0d", id), 64'(resp_s), 64'(es));
    chk($sformatf("resp_of id%0d", id), 64'(resp_of), 64'(eo));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      resp_ready = wrong ? ~oh : 4'b0;
      @(negedge clk);
      chk($sformatf("stall resp_valid id%0d c%0d", id, k), 64'(resp_valid), 64'(oh));
      chk($sformatf("stall resp_s id%0d c%0d", id, k), 64'(resp_s), 64'(es));
      chk($sformatf("stall req_ready id%0d c%0d", id, k), 64'(req_ready), 64'd0);
      chk($sformatf("stall busy id%0d c%0d", id, k), 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    resp_ready = oh;
    @(posedge clk); #1;
    resp_ready = 4'b0;
    chk($sformatf("post-hs busy id%0d", id), 64'(busy), 64'd0);
    chk($sformatf("post-hs resp_valid id%0d", id), 64'(resp_valid), 64'd0);
  endtask

  initial begin
    tbl[0] = '{id: 0, a: 32'h42360000, b: 32'h42360000, s: 32'h45016400, of: 1'b0};
    tbl[1] = '{id: 2, a: 32'h7F514CCD, b: 32'h7F514CCD, s: 32'h00000000, of: 1'b1};
    tbl[2] = '{id: 3, a: 32'h00000000, b: 32'hC2360000, s: 32'h00000000, of: 1'b0};
    tbl[3] = '{id: 1, a: 32'h3F99999A, b: 32'hC0133333, s: 32'hC030A3D7, of: 1'b0};

    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // A request during reset must not be accepted.
    req_valid = 4'b0100;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset mul_a", 64'(mul_a), 64'd0);
    chk("reset mul_b", 64'(mul_b), 64'd0);
    chk("reset resp_s", 64'(resp_s), 64'd0);
    chk("reset resp_of", 64'(resp_of), 64'd0);
    chk("reset grant_id", 64'(grant_id), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    reset     = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle no-req busy", 64'(busy), 64'd0);
    chk("idle no-req mul_a", 64'(mul_a), 64'd0);
    @(posedge clk); #1;

    // All four contend from rr_ptr=0: served 0,1,2,3, then req1 alone after the wrap.
    for (int i = 0; i < 4; i++) set_ops(i, 32'h3F99999A, 32'hC0133333);
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) op(i, 32'hC030A3D7, 1'b0, 0, 1'b0);
    req_valid = 4'b0010;
    op(1, 32'hC030A3D7, 1'b0, 0, 1'b0);

    // Single-requester vectors; requester deasserts during WAIT and still gets its result.
    for (int v = 0; v < 4; v++) begin
      set_ops(tbl[v].id, tbl[v].a, tbl[v].b);
      req_valid = 4'(1 << tbl[v].id);
      op(tbl[v].id, tbl[v].s, tbl[v].of, 0, 1'b0);
    end

    // rr_ptr=2: req2 wins over req0, RESP stalls 5 cycles with no new grant, then req0.
    set_ops(2, 32'h7F514CCD, 32'h7F514CCD);
    set_ops(0, 32'h42360000, 32'h42360000);
    req_valid = 4'b0101;
    op(2, 32'h00000000, 1'b1, 5, 1'b0);
    op(0, 32'h45016400, 1'b0, 0, 1'b0);

    // resp_ready on the wrong indices must not complete the handshake.
    set_ops(1, 32'h3F99999A, 32'hC0133333);
    req_valid = 4'b0010;
    op(1, 32'hC030A3D7, 1'b0, 2, 1'b1);

    // rr_ptr=2: req3 wins, reset mid-WAIT aborts it; afterwards rr_ptr=0 so req1 goes first.
    set_ops(3, 32'h42360000, 32'h42360000);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5 first grant", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5 wait mul_a", 64'(mul_a), 64'h42360000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t5 busy", 64'(busy), 64'd0);
    chk("t5 resp_valid", 64'(resp_valid), 64'd0);
    chk("t5 mul_a", 64'(mul_a), 64'd0);
    chk("t5 grant_id", 64'(grant_id), 64'd0);
    chk("t5 regrant", 64'(req_ready), 64'b0010);
    op(1, 32'hC030A3D7, 1'b0, 0, 1'b0);
    op(3, 32'h45016400, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
